i2c_target: RTL

// - I2C target (responder) for the on-chip register bank; the far-end counterpart of the I2C initiator.
// - Oversamples SCL/SDA with clk, detects START/STOP, matches a 7-bit address and ACKs it.
// - Write: first data byte loads the register pointer; later bytes write registers. Read: returns registers.
// - Pointer auto-increments after every data byte. Open-drain SDA only; no clock stretching.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_bus_sync.sv | 48 ++++
 rtl/i2c_target.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states and R/W bit values.
// Used by the target and, later, the initiator.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    MACK,
    IGNORE
  } state_t;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers with edge and START/STOP detection.
// Synchronizers reset to 1 so an idle bus produces no edges.
module i2c_bus_sync #(
  parameter int SYNC_LEN = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [SYNC_LEN-1:0] r_scl_q;
  logic [SYNC_LEN-1:0] r_sda_q;
  logic                r_scl_p;
  logic                r_sda_p;
  logic                w_scl;
  logic                w_sda;

  assign w_scl = r_scl_q[SYNC_LEN-1];
  assign w_sda = r_sda_q[SYNC_LEN-1];

  // shift pad inputs through the sync chain, keep previous synced sample
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_scl_q <= '1;
      r_sda_q <= '1;
      r_scl_p <= 1'b1;
      r_sda_p <= 1'b1;
    end else begin
      r_scl_q <= {r_scl_q[SYNC_LEN-2:0], i_scl};
      r_sda_q <= {r_sda_q[SYNC_LEN-2:0], i_sda};
      r_scl_p <= w_scl;
      r_sda_p <= w_sda;
    end
  end

  assign o_sda      = w_sda;
  assign o_scl_rise = w_scl & ~r_scl_p;
  assign o_scl_fall = ~w_scl & r_scl_p;
  assign o_start    = w_scl & r_sda_p & ~w_sda;
  assign o_stop     = w_scl & ~r_sda_p & w_sda;

endmodule

// File: rtl/i2c_target.sv
// I2C target for the register bank: address match, pointer
// write, register write/read with auto-increment pointer.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h42,
  parameter int         SYNC_LEN = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  logic w_sda, w_rise, w_fall, w_start, w_stop;

  i2c_bus_sync #(.SYNC_LEN(SYNC_LEN)) u_sync (
    .clk        (clk),
    .reset      (reset),
    .i_scl      (scl_in),
    .i_sda      (sda_in),
    .o_sda      (w_sda),
    .o_scl_rise (w_rise),
    .o_scl_fall (w_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  state_t     r_state, w_state_n;
  logic [2:0] r_bitcnt, w_bitcnt_n;
  logic       r_ack, w_ack_n;
  logic [7:0] r_shift, w_shift_n;
  logic       r_rw, w_rw_n;
  logic       r_oe, w_oe_n;
  logic [7:0] r_addr, w_addr_n;
  logic [7:0] r_wdata, w_wdata_n;
  logic       r_busy, w_busy_n;
  logic       r_wr, w_wr_n;
  logic       r_rd, w_rd_n;
  logic       r_rd_d;
  logic [7:0] w_byte;

  assign w_byte = {r_shift[6:0], w_sda};

  // state register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_n;
  end

  // next-state and datapath decisions; r_ack marks the ACK half of a byte
  always_comb begin
    w_state_n  = r_state;
    w_bitcnt_n = r_bitcnt;
    w_ack_n    = r_ack;
    w_shift_n  = r_shift;
    w_rw_n     = r_rw;
    w_oe_n     = r_oe;
    w_addr_n   = r_addr;
    w_wdata_n  = r_wdata;
    w_busy_n   = r_busy;
    w_wr_n     = 1'b0;
    w_rd_n     = 1'b0;
    if (r_wr) w_addr_n = r_addr + 8'd1;
    if (r_rd_d) w_shift_n = reg_rdata;
    if (w_stop) begin
      w_state_n  = IDLE;
      w_oe_n     = 1'b0;
      w_busy_n   = 1'b0;
      w_bitcnt_n = 3'd0;
      w_ack_n    = 1'b0;
    end else if (w_start) begin
      w_state_n  = ADDR;
      w_oe_n     = 1'b0;
      w_busy_n   = 1'b1;
      w_bitcnt_n = 3'd0;
      w_ack_n    = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
        end
        ADDR: if (w_rise) begin
          w_shift_n  = w_byte;
          w_bitcnt_n = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) begin
            w_rw_n    = w_sda;
            w_ack_n   = 1'b0;
            w_state_n = (r_shift[6:0] == DEV_ADDR) ? ADDR_ACK : IGNORE;
          end
        end
        ADDR_ACK: begin
          if (w_rise && r_ack && r_rw == RW_READ) w_rd_n = 1'b1;
          if (w_fall) begin
            if (!r_ack) begin
              w_oe_n  = 1'b1;
              w_ack_n = 1'b1;
            end else begin
              w_ack_n    = 1'b0;
              w_bitcnt_n = 3'd0;
              if (r_rw == RW_READ) begin
                w_oe_n    = ~r_shift[7];
                w_state_n = RDATA;
              end else begin
                w_oe_n    = 1'b0;
                w_state_n = PTR;
              end
            end
          end
        end
        PTR, WDATA: if (w_rise) begin
          w_shift_n  = w_byte;
          w_bitcnt_n = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) begin
            w_ack_n = 1'b0;
            if (r_state == WDATA) begin
              w_wr_n    = 1'b1;
              w_wdata_n = w_byte;
              w_state_n = WDATA_ACK;
            end else begin
              w_state_n = PTR_ACK;
            end
          end
        end
        PTR_ACK, WDATA_ACK: if (w_fall) begin
          if (!r_ack) begin
            w_oe_n  = 1'b1;
            w_ack_n = 1'b1;
          end else begin
            w_oe_n     = 1'b0;
            w_ack_n    = 1'b0;
            w_bitcnt_n = 3'd0;
            w_state_n  = WDATA;
            if (r_state == PTR_ACK) w_addr_n = r_shift;
          end
        end
        RDATA: begin
          if (w_rise) begin
            w_shift_n  = {r_shift[6:0], 1'b0};
            w_bitcnt_n = r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              w_ack_n   = 1'b0;
              w_state_n = MACK;
            end
          end else if (w_fall) begin
            w_oe_n = ~r_shift[7];
          end
        end
        MACK: begin
          if (w_fall) begin
            if (!r_ack) begin
              w_oe_n = 1'b0;
            end else begin
              w_oe_n     = ~r_shift[7];
              w_ack_n    = 1'b0;
              w_bitcnt_n = 3'd0;
              w_state_n  = RDATA;
            end
          end else if (w_rise && !r_ack) begin
            if (!w_sda) begin
              w_addr_n = r_addr + 8'd1;
              w_rd_n   = 1'b1;
              w_ack_n  = 1'b1;
            end else begin
              w_state_n = IGNORE;
            end
          end
        end
        IGNORE: w_oe_n = 1'b0;
        default: w_state_n = IDLE;
      endcase
    end
  end

  // datapath registers; reset releases SDA and clears strobes at once
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bitcnt <= 3'd0;
      r_ack    <= 1'b0;
      r_shift  <= 8'd0;
      r_rw     <= RW_WRITE;
      r_oe     <= 1'b0;
      r_addr   <= 8'd0;
      r_wdata  <= 8'd0;
      r_busy   <= 1'b0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_rd_d   <= 1'b0;
    end else begin
      r_bitcnt <= w_bitcnt_n;
      r_ack    <= w_ack_n;
      r_shift  <= w_shift_n;
      r_rw     <= w_rw_n;
      r_oe     <= w_oe_n;
      r_addr   <= w_addr_n;
      r_wdata  <= w_wdata_n;
      r_busy   <= w_busy_n;
      r_wr     <= w_wr_n;
      r_rd     <= w_rd_n;
      r_rd_d   <= r_rd;
    end
  end

  assign sda_oe    = r_oe;
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign reg_wr    = r_wr;
  assign reg_rd    = r_rd;
  assign busy      = r_busy;

endmodule
